instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Fetch front end that sits directly upstream of the instruction decoder. It generates word-aligned fetch-group addresses for the instruction memory, accepts IPC-wide instruction groups back, and buffers them in a small FIFO. It presents one group per cycle to the decoder on `DEC_data`/`DEC_dataValid`, with `DEC_ready` back-pressure. A redirect input flushes the queue and restarts fetch at a new PC.

## Interface
- `ADDRESS_WIDTH`, 10: instruction-memory word address width; PC is a word address.
- `DATA_WIDTH`, 32: instruction width.
- `IPC`, 4: instructions per fetch group; PC advances by IPC per request.
- `QUEUE_DEPTH`, 4: FIFO entries (fetch groups); power of two, ≥2.
- `RESET_PC`, 0: fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `IM_req`  out  1  fetch request to instruction memory, this cycle.
- `IM_addr`  out  ADDRESS_WIDTH  word address of instruction 0 of the requested group.
- `IM_data`  in  IPC*DATA_WIDTH  returned group; instruction k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `IM_dataValid`  in  1  `IM_data` valid; exactly one cycle after the matching `IM_req`.
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  ADDRESS_WIDTH  new fetch address, sampled when `redirect`=1.
- `DEC_data`  out  IPC*DATA_WIDTH  head fetch group, same lane packing as `IM_data`.
- `DEC_dataValid`  out  1  queue non-empty.
- `DEC_ready`  in  1  decoder accepts head this cycle.
- `queue_count`  out  clog2(QUEUE_DEPTH)+1  current FIFO occupancy.

## Operation
- State: `pc` (ADDRESS_WIDTH), FIFO storage plus `rd_ptr`/`wr_ptr` (clog2 depth, wrap naturally), `count`, and `inflight` (1 bit = registered `IM_req`).
- Reset values: `pc`=RESET_PC, `count`=0, pointers=0, `inflight`=0. While `rst`=1: `IM_req`=0, `DEC_dataValid`=0, `DEC_data`=0, `queue_count`=0.
- Request issue (combinational from state): `IM_req` = !rst && !redirect && (count + inflight < QUEUE_DEPTH); `IM_addr`=pc. Credit check ignores a same-cycle pop (conservative), so the FIFO never overflows.
- On issue: pc ← pc + IPC, modulo 2^ADDRESS_WIDTH (wraps, no flag).
- Push: `IM_dataValid` && `inflight` && !redirect → write `IM_data` at wr_ptr. `IM_dataValid` with `inflight`=0 is ignored.
- Pop: `DEC_dataValid` && `DEC_ready` && !redirect → rd_ptr advances.
- Same-cycle push and pop: count unchanged; both pointers advance. Push into an empty queue is not bypassed; the group becomes visible the next cycle.
- `DEC_dataValid` = (count≠0). `DEC_data` = entry[rd_ptr] when valid, else 0.
- Redirect (highest priority after rst), in the cycle `redirect`=1:
  - `IM_req`=0.
  - Any same-cycle push or pop is suppressed.
  - Next state: count=0, rd_ptr=wr_ptr=0, pc=redirect_pc, inflight=0, so the response to the pre-redirect request is discarded.
  - Fetch resumes the following cycle at redirect_pc.
- rst asserted mid-operation: the full reset state is applied at the next edge; any response arriving after that edge is dropped (`inflight`=0).

## Timing
- Cold start: cycle 0 is the first cycle with rst=0; `IM_req`=1, `IM_addr`=RESET_PC. Cycle 1: `IM_dataValid`, push. Cycle 2: `DEC_dataValid`=1. Fetch-to-decode latency is 2 cycles.
- Steady state with `DEC_ready`=1 sustains one group per cycle.
- Redirect at cycle r: first new request at r+1, data at r+2, `DEC_dataValid` at r+3.
- Full: count + inflight = QUEUE_DEPTH → `IM_req`=0 until a pop has lowered count (the request reissues the cycle after the pop).

## Test plan
- Reset/start-up: rst for 3 cycles, then release with DEC_ready=1 and the memory model returning addr-tagged data → IM_addr sequence 0, 4, 8, …; first DEC_dataValid 2 cycles after release; groups arrive in order with none lost.
- Back-pressure: DEC_ready=0 → exactly 4 requests issue, then IM_req=0 and queue_count=4. Raise DEC_ready → groups 0, 4, 8, 12 pop in order, and fetch restarts at 16.
- Redirect with an in-flight request: at a cycle with IM_req=1 (addr 8), assert redirect with redirect_pc=0x100 → the next-cycle response is dropped, the queue empties, the next IM_addr is 0x100, and the first decoded group is 0x100.
- PC wrap: RESET_PC=0x3FC, ADDRESS_WIDTH=10 → IM_addr 0x3FC then 0x000.
- Simultaneous push/pop at count=2 → count stays 2 and order is preserved. A stray IM_dataValid with no request → ignored, count unchanged.
- Reset mid-stream with queue_count=3 → next cycle all outputs are zero and the trailing response is dropped; the restart fetches RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: issues IPC-wide fetch requests, buffers returned groups in a
// small FIFO and hands them to the decoder; redirect flushes and restarts fetch.
module instruction_fetch_queue #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int IPC = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                IM_req,
    output logic [ADDRESS_WIDTH-1:0]            IM_addr,
    input  logic [IPC*DATA_WIDTH-1:0]           IM_data,
    input  logic                                IM_dataValid,
    input  logic                                redirect,
    input  logic [ADDRESS_WIDTH-1:0]            redirect_pc,
    output logic [IPC*DATA_WIDTH-1:0]           DEC_data,
    output logic                                DEC_dataValid,
    input  logic                                DEC_ready,
    output logic [$clog2(QUEUE_DEPTH):0]        queue_count
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GROUP_W = IPC * DATA_WIDTH;
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(QUEUE_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(IPC);

    logic [GROUP_W-1:0]       storage [QUEUE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;
    logic                     inflight;

    logic [CNT_W:0]           credit_used;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     has_data;

    // Credit counts the outstanding request so a response always has a free slot.
    always_comb begin
        has_data    = (count != '0);
        credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        issue       = !rst && !redirect && (credit_used < DEPTH_LIMIT);
        push        = !rst && IM_dataValid && inflight && !redirect;
        pop         = !rst && has_data && DEC_ready && !redirect;
    end

    assign IM_req        = issue;
    assign IM_addr       = pc;
    assign DEC_dataValid = !rst && has_data;
    assign DEC_data      = DEC_dataValid ? storage[rd_ptr] : '0;
    assign queue_count   = rst ? '0 : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc <= pc + PC_STEP;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= IM_data;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized bench for instruction_fetch_queue against a queue-based reference
// model; a second instance with RESET_PC=0x3FC exercises PC wrap-around.
module tb_instruction_fetch_queue;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int IPC = 4;
    localparam int DEPTH = 4;
    localparam int GW = IPC * DW;
    localparam logic [AW-1:0] WRAP_PC = 10'h3FC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          IM_req;
    logic [AW-1:0] IM_addr;
    logic [GW-1:0] IM_data;
    logic          IM_dataValid;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [GW-1:0] DEC_data;
    logic          DEC_dataValid;
    logic          DEC_ready;
    logic [2:0]    queue_count;

    logic          w_req;
    logic [AW-1:0] w_addr;
    logic          w_valid;
    logic [GW-1:0] w_dec_data;
    logic          w_dec_valid;
    logic [2:0]    w_count;

    instruction_fetch_queue #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .IPC(IPC), .QUEUE_DEPTH(DEPTH), .RESET_PC(10'h000)
    ) dut (
        .clk(clk), .rst(rst), .IM_req(IM_req), .IM_addr(IM_addr), .IM_data(IM_data),
        .IM_dataValid(IM_dataValid), .redirect(redirect), .redirect_pc(redirect_pc),
        .DEC_data(DEC_data), .DEC_dataValid(DEC_dataValid), .DEC_ready(DEC_ready),
        .queue_count(queue_count)
    );

    instruction_fetch_queue #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .IPC(IPC), .QUEUE_DEPTH(DEPTH), .RESET_PC(WRAP_PC)
    ) dut_wrap (
        .clk(clk), .rst(rst), .IM_req(w_req), .IM_addr(w_addr), .IM_data('0),
        .IM_dataValid(w_valid), .redirect(1'b0), .redirect_pc('0),
        .DEC_data(w_dec_data), .DEC_dataValid(w_dec_valid), .DEC_ready(1'b1),
        .queue_count(w_count)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model state
    logic [GW-1:0] m_q[$];
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] m_inflight_addr = '0;
    bit            m_inflight = 1'b0;
    logic [AW-1:0] w_pc = WRAP_PC;

    // Memory model state (responds one cycle after each observed request)
    bit            mem_pend = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    bit            w_pend = 1'b0;

    task automatic check(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [GW-1:0] make_group(input logic [AW-1:0] a);
        logic [GW-1:0] g;
        g = '0;
        for (int k = 0; k < IPC; k++) begin
            g[k*DW +: DW] = {22'h2A5A5A, a + AW'(k)};
        end
        return g;
    endfunction

    task automatic step(input bit r, input bit ready, input bit redir,
                        input logic [AW-1:0] rpc, input bit stray_ok);
        bit            exp_req;
        bit            exp_valid;
        logic [GW-1:0] exp_data;
        int            exp_count;
        rst          = r;
        DEC_ready    = ready;
        redirect     = redir;
        redirect_pc  = rpc;
        IM_dataValid = mem_pend || (stray_ok && ($urandom_range(7) == 0));
        IM_data      = mem_pend ? make_group(mem_addr)
                                : {$urandom(), $urandom(), $urandom(), $urandom()};
        w_valid      = w_pend;
        #1;
        exp_req   = !r && !redir && ((m_q.size() + int'(m_inflight)) < DEPTH);
        exp_valid = !r && (m_q.size() != 0);
        exp_data  = exp_valid ? m_q[0] : '0;
        exp_count = r ? 0 : m_q.size();
        check("IM_req", GW'(IM_req), GW'(exp_req));
        if (exp_req) check("IM_addr", GW'(IM_addr), GW'(m_pc));
        check("DEC_dataValid", GW'(DEC_dataValid), GW'(exp_valid));
        check("DEC_data", DEC_data, exp_data);
        check("queue_count", GW'(queue_count), GW'(exp_count));
        check("wrap_req", GW'(w_req), GW'(!r));
        if (!r) check("wrap_addr", GW'(w_addr), GW'(w_pc));

        if (r) begin
            m_q.delete();
            m_pc       = '0;
            m_inflight = 1'b0;
        end else if (redir) begin
            m_q.delete();
            m_pc       = rpc;
            m_inflight = 1'b0;
        end else begin
            if (exp_valid && ready) void'(m_q.pop_front());
            if (IM_dataValid && m_inflight) m_q.push_back(make_group(m_inflight_addr));
            m_inflight      = exp_req;
            m_inflight_addr = m_pc;
            if (exp_req) m_pc = m_pc + AW'(IPC);
        end
        w_pc = r ? WRAP_PC : w_pc + AW'(IPC);

        mem_pend = IM_req;
        mem_addr = IM_addr;
        w_pend   = w_req;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; DEC_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        IM_data = '0; IM_dataValid = 1'b0; w_valid = 1'b0;
        @(negedge clk);
        repeat (3) step(1, 1, 0, '0, 0);
        // Cold start, streaming
        repeat (30) step(0, 1, 0, '0, 0);
        // Back-pressure until full, then drain
        repeat (10) step(0, 0, 0, '0, 0);
        check("full_count", GW'(queue_count), GW'(DEPTH));
        repeat (12) step(0, 1, 0, '0, 0);
        // Redirect while fetch is streaming
        step(0, 1, 1, 10'h100, 0);
        repeat (8) step(0, 1, 0, '0, 0);
        // Reset mid-stream with three groups queued
        repeat (3) step(0, 1, 1, 10'h040, 0);
        for (int i = 0; i < 20 && m_q.size() != 3; i++) step(0, 0, 0, '0, 0);
        check("reach_count3", GW'(queue_count), GW'(3));
        step(1, 0, 0, '0, 0);
        repeat (10) step(0, 1, 0, '0, 0);
        // Random traffic: back-pressure, redirects, stray responses, resets
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(63) == 0, $urandom_range(3) != 0,
                 $urandom_range(15) == 0, AW'($urandom()), 1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
